ppp_controller: RTL

Sequencing controller for the ping/pang/pung packet buffers. It owns the buffer rotation and drives the `sn_sel`, `cpu_sel` and `fwd_sel` selects of the buffer mux block, so that the snooper fills buffers, the CPU filters them and the forwarder drains accepted ones. It keeps packet order, skips rejected buffers, and carries each packet's byte length from the snooper to the CPU and the forwarder.

---
 rtl/ppp_controller_pkg.sv | 34 +++
 rtl/ppp_bufstate.sv | 53 +++++
 rtl/ppp_controller.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ppp_controller_pkg.sv
// Shared definitions for the ping/pang/pung buffer sequencer: sel encodings,
// buffer-state enum and rotation-pointer helpers.
package ppp_controller_pkg;

  localparam int NUM_BUF = 3;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_PING = 2'b01;
  localparam logic [1:0] SEL_PANG = 2'b10;
  localparam logic [1:0] SEL_PUNG = 2'b11;

  typedef enum logic [2:0] {
    BUF_FREE,
    BUF_FILLING,
    BUF_FULL,
    BUF_READING,
    BUF_ACCEPTED,
    BUF_SENDING,
    BUF_REJECTED
  } buf_state_e;

  function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
    return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  endfunction

  function automatic logic [1:0] ptr_to_sel(input logic [1:0] ptr);
    case (ptr)
      2'd0:    return SEL_PING;
      2'd1:    return SEL_PANG;
      default: return SEL_PUNG;
    endcase
  endfunction

endpackage

// File: rtl/ppp_bufstate.sv
// One packet buffer's ownership state and stored byte length.
//   state        | meaning
//   BUF_FREE     | empty, waiting for the snooper
//   BUF_FILLING  | snooper writing
//   BUF_FULL     | packet complete, waiting for the CPU
//   BUF_READING  | CPU filtering
//   BUF_ACCEPTED | accepted, waiting for the forwarder
//   BUF_SENDING  | forwarder draining
//   BUF_REJECTED | rejected, forwarder will skip and free it
module ppp_bufstate
  import ppp_controller_pkg::*;
#(
  parameter int LEN_WIDTH = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sn_take,
  input  logic                 sn_give,
  input  logic [LEN_WIDTH-1:0] sn_len,
  input  logic                 cpu_take,
  input  logic                 cpu_acc,
  input  logic                 cpu_rej,
  input  logic                 fwd_take,
  input  logic                 fwd_free,
  output buf_state_e           state,
  output logic [LEN_WIDTH-1:0] len
);

  // The top only raises one of these per buffer per cycle, since each
  // request is qualified by a distinct current state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BUF_FREE;
      len   <= '0;
    end else if (sn_take) begin
      state <= BUF_FILLING;
    end else if (sn_give) begin
      state <= BUF_FULL;
      len   <= sn_len;
    end else if (cpu_take) begin
      state <= BUF_READING;
    end else if (cpu_rej) begin
      state <= BUF_REJECTED;
    end else if (cpu_acc) begin
      state <= BUF_ACCEPTED;
    end else if (fwd_take) begin
      state <= BUF_SENDING;
    end else if (fwd_free) begin
      state <= BUF_FREE;
    end
  end

endmodule

// File: rtl/ppp_controller.sv
// Ping/pang/pung buffer rotation between snooper, CPU and forwarder.
// Optional packet counters enabled by defining PPP_PKT_COUNT_EN.
module ppp_controller
  import ppp_controller_pkg::*;
#(
  parameter int LEN_WIDTH = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sn_done,
  input  logic [LEN_WIDTH-1:0] sn_len,
  input  logic                 cpu_accept,
  input  logic                 cpu_reject,
  input  logic                 fwd_done,
  output logic [1:0]           sn_sel,
  output logic [1:0]           cpu_sel,
  output logic [1:0]           fwd_sel,
  output logic                 sn_grant,
  output logic                 cpu_grant,
  output logic                 fwd_grant,
  output logic [LEN_WIDTH-1:0] cpu_len,
`ifdef PPP_PKT_COUNT_EN
  output logic [LEN_WIDTH-1:0] fwd_len,
  output logic [31:0]          acc_count,
  output logic [31:0]          rej_count
`else
  output logic [LEN_WIDTH-1:0] fwd_len
`endif
);

  logic [1:0] sn_ptr, cpu_ptr, fwd_ptr;
  logic       sn_active, cpu_active, fwd_active;

  buf_state_e           buf_st  [NUM_BUF];
  logic [LEN_WIDTH-1:0] buf_len [NUM_BUF];

  logic [NUM_BUF-1:0] sn_take, sn_give, cpu_take, cpu_acc, cpu_rej;
  logic [NUM_BUF-1:0] fwd_take, fwd_give, fwd_skip;

  logic [LEN_WIDTH-1:0] cpu_len_nxt, fwd_len_nxt;

  for (genvar i = 0; i < NUM_BUF; i++) begin : g_buf
    // Idle agents grab their pointed buffer; active agents release it.
    assign sn_take[i]  = !sn_active  && sn_ptr  == 2'(i) && buf_st[i] == BUF_FREE;
    assign sn_give[i]  =  sn_active  && sn_ptr  == 2'(i) && sn_done;
    assign cpu_take[i] = !cpu_active && cpu_ptr == 2'(i) && buf_st[i] == BUF_FULL;
    assign cpu_rej[i]  =  cpu_active && cpu_ptr == 2'(i) && cpu_reject;
    assign cpu_acc[i]  =  cpu_active && cpu_ptr == 2'(i) && cpu_accept && !cpu_reject;
    assign fwd_take[i] = !fwd_active && fwd_ptr == 2'(i) && buf_st[i] == BUF_ACCEPTED;
    assign fwd_give[i] =  fwd_active && fwd_ptr == 2'(i) && fwd_done;
    assign fwd_skip[i] = !fwd_active && fwd_ptr == 2'(i) && buf_st[i] == BUF_REJECTED;

    ppp_bufstate #(.LEN_WIDTH(LEN_WIDTH)) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .sn_take  (sn_take[i]),
      .sn_give  (sn_give[i]),
      .sn_len   (sn_len),
      .cpu_take (cpu_take[i]),
      .cpu_acc  (cpu_acc[i]),
      .cpu_rej  (cpu_rej[i]),
      .fwd_take (fwd_take[i]),
      .fwd_free (fwd_give[i] | fwd_skip[i]),
      .state    (buf_st[i]),
      .len      (buf_len[i])
    );
  end

  always_comb begin
    cpu_len_nxt = '0;
    fwd_len_nxt = '0;
    for (int j = 0; j < NUM_BUF; j++) begin
      if (cpu_take[j]) cpu_len_nxt = buf_len[j];
      if (fwd_take[j]) fwd_len_nxt = buf_len[j];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sn_ptr     <= 2'd0;
      cpu_ptr    <= 2'd0;
      fwd_ptr    <= 2'd0;
      sn_active  <= 1'b0;
      cpu_active <= 1'b0;
      fwd_active <= 1'b0;
      sn_sel     <= SEL_NONE;
      cpu_sel    <= SEL_NONE;
      fwd_sel    <= SEL_NONE;
      cpu_len    <= '0;
      fwd_len    <= '0;
    end else begin
      if (|sn_take) begin
        sn_active <= 1'b1;
        sn_sel    <= ptr_to_sel(sn_ptr);
      end else if (|sn_give) begin
        sn_active <= 1'b0;
        sn_sel    <= SEL_NONE;
        sn_ptr    <= ptr_inc(sn_ptr);
      end

      if (|cpu_take) begin
        cpu_active <= 1'b1;
        cpu_sel    <= ptr_to_sel(cpu_ptr);
        cpu_len    <= cpu_len_nxt;
      end else if (|(cpu_acc | cpu_rej)) begin
        cpu_active <= 1'b0;
        cpu_sel    <= SEL_NONE;
        cpu_len    <= '0;
        cpu_ptr    <= ptr_inc(cpu_ptr);
      end

      // A rejected buffer costs the forwarder one cycle and no grant.
      if (|fwd_take) begin
        fwd_active <= 1'b1;
        fwd_sel    <= ptr_to_sel(fwd_ptr);
        fwd_len    <= fwd_len_nxt;
      end else if (|fwd_give) begin
        fwd_active <= 1'b0;
        fwd_sel    <= SEL_NONE;
        fwd_len    <= '0;
        fwd_ptr    <= ptr_inc(fwd_ptr);
      end else if (|fwd_skip) begin
        fwd_ptr    <= ptr_inc(fwd_ptr);
      end
    end
  end

  assign sn_grant  = |sn_sel;
  assign cpu_grant = |cpu_sel;
  assign fwd_grant = |fwd_sel;

`ifdef PPP_PKT_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_count <= '0;
      rej_count <= '0;
    end else begin
      if (|cpu_acc) acc_count <= acc_count + 32'd1;
      if (|cpu_rej) rej_count <= rej_count + 32'd1;
    end
  end
`endif

endmodule
